// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch request, response and decode-side handshake bundle
interface fetch_queue_if #(
  parameter int DATA_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              deq_valid;
  logic              deq_ready;
  logic [DATA_W-1:0] deq_data;

  modport master (
    output req_valid, resp_valid, resp_data, deq_ready,
    input  req_ready, deq_valid, deq_data
  );

  modport slave (
    input  req_valid, resp_valid, resp_data, deq_ready,
    output req_ready, deq_valid, deq_data
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order fetch queue with request credits and flush-safe response cancellation
module fetch_queue #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  fetch_queue_if.slave     bus,
  output logic [CNT_W-1:0] count,
  output logic             discarding
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int SUM_W = CNT_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  discard;

  logic             resp_ok;
  logic             req_fire;
  logic             push;
  logic             drop;
  logic             pop;
  logic [SUM_W-1:0] credit_sum;

  // A response with nothing in flight is a protocol violation and is ignored outright.
  always_comb begin
    credit_sum    = {1'b0, count} + {1'b0, outstanding};
    bus.req_ready = resetn & ~flush & (credit_sum < SUM_W'(DEPTH));
    bus.deq_valid = resetn & (count != '0);
    bus.deq_data  = mem[rd_ptr];
    discarding    = (discard != '0);
    resp_ok       = bus.resp_valid & (outstanding != '0);
    req_fire      = bus.req_valid & bus.req_ready;
    push          = resp_ok & ~flush & (discard == '0);
    drop          = resp_ok & ~flush & (discard != '0);
    pop           = bus.deq_valid & bus.deq_ready;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else if (flush) begin
      // Every response still in flight after this cycle belongs to a cancelled request.
      count       <= '0;
      rd_ptr      <= wr_ptr;
      outstanding <= outstanding - CNT_W'(resp_ok);
      discard     <= outstanding - CNT_W'(resp_ok);
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (drop) begin
        discard <= discard - CNT_W'(1);
      end
      count       <= count + CNT_W'(push) - CNT_W'(pop);
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(resp_ok);
    end
  end

  // Storage is deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (resetn && push) begin
      mem[wr_ptr] <= bus.resp_data;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized scoreboard bench for fetch_queue against a queue-based reference
module tb_fetch_queue;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             flush = 1'b0;
  logic [CNT_W-1:0] count;
  logic             discarding;

  fetch_queue_if #(.DATA_W(DATA_W)) bus ();

  fetch_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .bus        (bus.slave),
    .count      (count),
    .discarding (discarding)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_count = 0;
  int m_out = 0;
  int m_disc = 0;
  int viol = 0;
  bit started = 0;
  logic [DATA_W-1:0] sb_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the queue is a list, in-flight requests and pending drops are plain counts.
  task automatic model_update();
    bit rok, fire, push, pop;
    if (!resetn) begin
      m_count = 0; m_out = 0; m_disc = 0;
      sb_q.delete();
      return;
    end
    rok  = bus.resp_valid && (m_out > 0);
    if (bus.resp_valid && m_out == 0) viol++;
    fire = bus.req_valid && !flush && (m_count + m_out < DEPTH);
    if (flush) begin
      if (rok) m_out--;
      m_disc  = m_out;
      m_count = 0;
      sb_q.delete();
    end else begin
      pop  = (m_count > 0) && bus.deq_ready;
      push = rok && (m_disc == 0);
      if (rok && m_disc > 0) m_disc--;
      if (push) begin
        if (m_count == DEPTH) begin
          errors++;
          $display("FAIL overflow push with count %0d", m_count);
        end
        sb_q.push_back(bus.resp_data);
      end
      m_count = m_count + int'(push) - int'(pop);
      m_out   = m_out + int'(fire) - int'(rok);
    end
  endtask

  task automatic step(input bit rv, input bit sv, input logic [63:0] d, input bit dr, input bit fl);
    bus.req_valid  = rv;
    bus.resp_valid = sv;
    bus.resp_data  = d;
    bus.deq_ready  = dr;
    flush          = fl;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0);
    started = 1;
    resetn = 1'b1;
  endtask

  initial begin
    logic [DATA_W-1:0] head;
    forever begin
      @(negedge clk);
      if (started) begin
        chk("req_ready", 64'(bus.req_ready),
            64'(resetn && !flush && (m_count + m_out < DEPTH)));
        chk("deq_valid", 64'(bus.deq_valid), 64'(resetn && m_count > 0));
        chk("count", 64'(count), 64'(m_count));
        chk("discarding", 64'(discarding), 64'(m_disc != 0));
        if (resetn && bus.deq_valid && bus.deq_ready && !flush) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL deq_data unexpected pop of %0h", bus.deq_data);
          end else begin
            head = sb_q.pop_front();
            chk("deq_data", bus.deq_data, head);
          end
        end
      end
    end
  end

  initial begin
    bus.req_valid = 0; bus.resp_valid = 0; bus.resp_data = '0; bus.deq_ready = 0;
    @(posedge clk); #1;
    do_reset();

    // Fill credits, then stream A..D out one cycle after each response.
    for (int i = 0; i < 5; i++) step(1, 0, '0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 64'hA0 + 64'(i), 1, 0);
    step(0, 0, '0, 1, 0);

    // Full queue blocks credit until a pop.
    for (int i = 0; i < 4; i++) step(1, 0, '0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 64'hB0 + 64'(i), 0, 0);
    chk("full_count", 64'(count), 64'd4);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 0, 0);
    chk("credit_after_pop", 64'(bus.req_ready), 64'd1);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 0);

    // Flush with two entries held and two in flight, then drop their responses.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, '0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 64'hC0 + 64'(i), 0, 0);
    step(0, 0, '0, 0, 1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_discarding", 64'(discarding), 64'd1);
    for (int i = 0; i < 2; i++) step(0, 1, 64'hDEAD, 0, 0);
    step(1, 0, '0, 0, 0);
    step(0, 1, 64'hBEEF, 1, 0);
    chk("post_flush_data", bus.deq_data, 64'hBEEF);
    step(0, 0, '0, 1, 0);

    // Flush coinciding with a response, three in flight.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, '0, 0, 0);
    step(0, 1, 64'hE0, 0, 1);
    for (int i = 0; i < 2; i++) step(0, 1, 64'hE1, 1, 0);
    chk("flush_resp_drained", 64'(discarding), 64'd0);

    // Streaming: push and pop every cycle, pointers wrap.
    do_reset();
    for (int i = 0; i < 10; i++) step(1, (m_out > 0), 64'hF0 + 64'(i), 1, 0);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(3) != 0, (m_out > 0) && ($urandom_range(2) != 0),
           {$urandom, $urandom}, $urandom_range(3) != 0, $urandom_range(19) == 0);
    end

    // Reset mid-run, then a stray response that must be ignored.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 64'h70 + 64'(i), 0, 0);
    resetn = 1'b0;
    step(0, 0, '0, 0, 0);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
    resetn = 1'b1;
    step(0, 1, 64'h99, 1, 0);
    chk("stray_ignored_count", 64'(count), 64'd0);
    chk("stray_ignored_deq", 64'(bus.deq_valid), 64'd0);
    chk("stray_flagged", 64'(viol), 64'd1);
    step(0, 0, '0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
